// File: rtl/cancid_pkg.sv
// Shared FSM encodings and saturating arithmetic for the per-stream regex context manager.
package cancid_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_SEED   = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;
  localparam state_t ST_COMMIT = 3'd5;

  // Operands are zero-extended to 32 bits; the result is clamped to 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    max = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > max) sum = max;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/cancid_ctx_ram.sv
// Context RAM: one write port plus NRD registered read ports; a read of the address being
// written returns the old word.
module cancid_ctx_ram
  import cancid_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 64,
  parameter int NRD   = 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [W-1:0]            wdata,
  input  logic [NRD-1:0][AW-1:0]  raddr,
  output logic [NRD-1:0][W-1:0]   rdata
);

  logic [W-1:0]          mem_q [DEPTH];
  logic [NRD-1:0][W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NRD; i++) rdata_d[i] = mem_q[raddr[i]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cancid_stream_ctx.sv
// Per-stream matcher context manager: seeds the external matcher, drains its latency and commits
// state plus saturating hit counts. Define CANCID_MULTI_HIT_EN to count every accept, not one per packet.
module cancid_stream_ctx
  import cancid_pkg::*;
#(
  parameter int STATE_W     = 11,
  parameter int NUM_STREAMS = 64,
  parameter int CNT_W       = 16,
  parameter int MATCH_LAT   = 1,
  localparam int ID_W       = $clog2(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_start,
  input  logic [ID_W-1:0]    stream_id,
  input  logic               new_stream,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_vld,
  input  logic               eop,
  output logic               ready,
  output logic               busy,
  output logic               fired,
  output logic [STATE_W-1:0] m_state_in,
  output logic               m_state_in_vld,
  output logic [7:0]         m_char,
  output logic               m_char_vld,
  input  logic [STATE_W-1:0] m_state_out,
  input  logic               m_accept,
  input  logic [ID_W-1:0]    cnt_rd_addr,
  output logic [CNT_W-1:0]   cnt_rd_data,
  output logic [CNT_W-1:0]   total_hits
);

  // state  | meaning
  // IDLE   | wait for pkt_start
  // LOAD   | state RAM read in flight
  // SEED   | present seed to matcher
  // ACTIVE | stream bytes until eop
  // DRAIN  | wait out matcher latency
  // COMMIT | write back state and counts

  state_t                   state_q, state_d;
  logic [ID_W-1:0]          sid_q, sid_d;
  logic                     new_q, new_d;
  logic                     en_q, en_d;
  logic [2:0]               drain_q, drain_d;
  logic [CNT_W-1:0]         hit_q, hit_d, hit_nxt;
  logic [NUM_STREAMS-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]         total_q, total_d;
  logic                     rd_vld_q, rd_vld_d;

  logic                     acc_take;
  logic                     commit_we;
  logic [CNT_W-1:0]         cnt_base;
  logic [CNT_W-1:0]         cnt_wdata;
  logic [0:0][ID_W-1:0]     st_raddr;
  logic [0:0][STATE_W-1:0]  st_rdata;
  logic [1:0][ID_W-1:0]     cnt_raddr;
  logic [1:0][CNT_W-1:0]    cnt_rdata;

  assign acc_take = m_accept &&
                    (state_q == ST_ACTIVE || state_q == ST_DRAIN || state_q == ST_COMMIT);

`ifdef CANCID_MULTI_HIT_EN
  assign hit_nxt = acc_take ? CNT_W'(sat_add(32'(hit_q), 32'd1, CNT_W)) : hit_q;
`else
  assign hit_nxt = (acc_take || hit_q != '0) ? CNT_W'(1) : '0;
`endif

  assign commit_we = (state_q == ST_COMMIT) && en_q;
  // Entries of an invalid stream read as zero regardless of stale RAM contents.
  assign cnt_base  = valid_q[sid_q] ? cnt_rdata[0] : '0;
  assign cnt_wdata = CNT_W'(sat_add(32'(cnt_base), 32'(hit_nxt), CNT_W));

  always_comb begin
    state_d = state_q;
    sid_d   = sid_q;
    new_d   = new_q;
    en_d    = en_q;
    drain_d = drain_q;
    hit_d   = hit_q;
    valid_d = valid_q;
    total_d = total_q;
    case (state_q)
      ST_IDLE: begin
        if (pkt_start) begin
          state_d = ST_LOAD;
          sid_d   = stream_id;
          new_d   = new_stream;
          en_d    = enable;
          hit_d   = '0;
        end
      end
      ST_LOAD: state_d = ST_SEED;
      ST_SEED: state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        hit_d = hit_nxt;
        if (eop) begin
          state_d = ST_DRAIN;
          drain_d = 3'(MATCH_LAT);
        end
      end
      ST_DRAIN: begin
        hit_d = hit_nxt;
        if (drain_q == 3'd0) state_d = ST_COMMIT;
        else                 drain_d = drain_q - 3'd1;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (en_q) begin
          hit_d          = hit_nxt;
          valid_d[sid_q] = 1'b1;
          total_d        = CNT_W'(sat_add(32'(total_q), 32'(hit_nxt), CNT_W));
        end else begin
          hit_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_vld_d = valid_q[cnt_rd_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sid_q    <= '0;
      new_q    <= 1'b0;
      en_q     <= 1'b0;
      drain_q  <= '0;
      hit_q    <= '0;
      valid_q  <= '0;
      total_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sid_q    <= sid_d;
      new_q    <= new_d;
      en_q     <= en_d;
      drain_q  <= drain_d;
      hit_q    <= hit_d;
      valid_q  <= valid_d;
      total_q  <= total_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // In IDLE the read follows stream_id so the word is ready the cycle after pkt_start.
  assign st_raddr  = (state_q == ST_IDLE) ? stream_id : sid_q;
  assign cnt_raddr = {cnt_rd_addr, sid_q};

  cancid_ctx_ram #(.W(STATE_W), .DEPTH(NUM_STREAMS), .NRD(1)) u_state_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_we),
    .waddr (sid_q),
    .wdata (m_state_out),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

  cancid_ctx_ram #(.W(CNT_W), .DEPTH(NUM_STREAMS), .NRD(2)) u_cnt_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_we),
    .waddr (sid_q),
    .wdata (cnt_wdata),
    .raddr (cnt_raddr),
    .rdata (cnt_rdata)
  );

  assign ready          = (state_q == ST_ACTIVE);
  assign busy           = (state_q != ST_IDLE);
  assign fired          = (hit_q != '0);
  assign m_state_in_vld = (state_q == ST_SEED);
  assign m_state_in     = (state_q == ST_SEED && !new_q && valid_q[sid_q]) ? st_rdata[0] : '0;
  assign m_char         = char_in;
  assign m_char_vld     = char_vld && ready;
  assign cnt_rd_data    = rd_vld_q ? cnt_rdata[1] : '0;
  assign total_hits     = total_q;

endmodule

// File: tb/tb_cancid_stream_ctx.sv
// Scoreboard bench for cancid_stream_ctx: the packet driver pushes expected seeds, commit results
// and count reads; a monitor pops them as the DUT presents each output.
module tb_cancid_stream_ctx;

  localparam int STATE_W = 11;
  localparam int NS      = 64;
  localparam int ID_W    = 6;
  localparam int CNT_W   = 4;
  localparam int ML      = 3;
  localparam int CMAX    = 15;
`ifdef CANCID_MULTI_HIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               pkt_start = 1'b0;
  logic [ID_W-1:0]    stream_id = '0;
  logic               new_stream = 1'b0;
  logic               enable = 1'b0;
  logic [7:0]         char_in = '0;
  logic               char_vld = 1'b0;
  logic               eop = 1'b0;
  logic               ready, busy, fired;
  logic [STATE_W-1:0] m_state_in;
  logic               m_state_in_vld;
  logic [7:0]         m_char;
  logic               m_char_vld;
  logic [STATE_W-1:0] m_state_out = '0;
  logic               m_accept = 1'b0;
  logic [ID_W-1:0]    cnt_rd_addr = '0;
  logic [CNT_W-1:0]   cnt_rd_data;
  logic [CNT_W-1:0]   total_hits;

  cancid_stream_ctx #(.STATE_W(STATE_W), .NUM_STREAMS(NS), .CNT_W(CNT_W), .MATCH_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .stream_id(stream_id),
    .new_stream(new_stream), .enable(enable), .char_in(char_in), .char_vld(char_vld),
    .eop(eop), .ready(ready), .busy(busy), .fired(fired), .m_state_in(m_state_in),
    .m_state_in_vld(m_state_in_vld), .m_char(m_char), .m_char_vld(m_char_vld),
    .m_state_out(m_state_out), .m_accept(m_accept), .cnt_rd_addr(cnt_rd_addr),
    .cnt_rd_data(cnt_rd_data), .total_hits(total_hits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fired;
    int   total;
    int   nchars;
  } cmt_t;

  int   tests = 0;
  int   fails = 0;
  int   seed_q[$];
  cmt_t cmt_q[$];
  int   rd_q[$];

  int   m_state[NS];
  bit   m_valid[NS];
  int   m_cnt[NS];
  int   m_total = 0;

  logic rd_issue = 1'b0;
  logic rd_pend = 1'b0;
  logic prev_busy = 1'b0;
  int   nchar_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  function automatic int sat(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  // Monitor: every DUT-presented output is compared against the head of its queue.
  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy  = 1'b0;
      nchar_seen = 0;
    end else begin
      if (m_char_vld) nchar_seen++;
      if (m_state_in_vld) begin
        if (seed_q.size() == 0) fail_evt("unexpected seed strobe");
        else chk("seed m_state_in", 32'(m_state_in), 32'(seed_q.pop_front()));
      end
      if (prev_busy && !busy) begin
        if (cmt_q.size() == 0) fail_evt("unexpected commit");
        else begin
          cmt_t c;
          c = cmt_q.pop_front();
          chk("commit fired", 32'(fired), 32'(c.fired));
          chk("commit total_hits", 32'(total_hits), 32'(c.total));
          chk("commit m_char_vld count", 32'(nchar_seen), 32'(c.nchars));
        end
        nchar_seen = 0;
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) fail_evt("unexpected count read");
        else chk("cnt_rd_data", 32'(cnt_rd_data), 32'(rd_q.pop_front()));
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) fail_evt("timeout waiting for idle");
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 20) begin
      @(posedge clk); #1;
      char_vld = 1'b0;
      g++;
    end
    if (g >= 20) fail_evt("timeout waiting for ready");
  endtask

  task automatic start_pkt(input int sid, input bit nw, input bit en, input int st_out,
                           input bit drop_tst);
    wait_idle();
    m_state_out = STATE_W'(st_out);
    seed_q.push_back((m_valid[sid] && !nw) ? m_state[sid] : 0);
    pkt_start  = 1'b1;
    stream_id  = ID_W'(sid);
    new_stream = nw;
    enable     = en;
    @(posedge clk); #1;
    pkt_start = 1'b0;
    if (drop_tst) begin
      char_vld = 1'b1;
      char_in  = 8'hEE;
      #1;
      chk("m_char_vld in LOAD", 32'(m_char_vld), 32'd0);
    end
    wait_ready();
    char_vld = 1'b0;
  endtask

  task automatic send_pkt(input int sid, input bit nw, input bit en, input int nchars,
                          input int n_acc, input bit late_acc, input int st_out,
                          input bit drop_tst, input bit ghost);
    int acc, hits, n;
    cmt_t c;
    acc  = n_acc + int'(late_acc);
    hits = MULTI ? acc : int'(acc > 0);
    start_pkt(sid, nw, en, st_out, drop_tst);
    if (en) begin
      m_cnt[sid]   = sat(m_valid[sid] ? m_cnt[sid] : 0, hits);
      m_state[sid] = st_out;
      m_valid[sid] = 1'b1;
      m_total      = sat(m_total, hits);
    end
    c.fired  = en && (acc > 0);
    c.total  = m_total;
    c.nchars = nchars;
    cmt_q.push_back(c);
    n = (nchars == 0) ? 1 : nchars;
    for (int i = 0; i < n; i++) begin
      char_vld = (nchars != 0);
      char_in  = 8'(i + 1);
      eop      = (i == n - 1);
      m_accept = (i < n_acc);
      if (ghost && i == 0) begin
        pkt_start = 1'b1;
        stream_id = ID_W'(sid + 1);
      end
      @(posedge clk); #1;
      pkt_start = 1'b0;
    end
    char_vld = 1'b0;
    eop      = 1'b0;
    m_accept = 1'b0;
    if (late_acc) begin
      repeat (ML - 1) begin
        @(posedge clk); #1;
      end
      m_accept = 1'b1;
      @(posedge clk); #1;
      m_accept = 1'b0;
    end
    wait_idle();
    @(posedge clk); #1;
  endtask

  task automatic rd_cnt(input int sid);
    wait_idle();
    rd_q.push_back(m_valid[sid] ? m_cnt[sid] : 0);
    cnt_rd_addr = ID_W'(sid);
    rd_issue    = 1'b1;
    @(posedge clk); #1;
    rd_issue = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_state[i] = 0;
      m_valid[i] = 1'b0;
      m_cnt[i]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset fired", 32'(fired), 32'd0);
    chk("reset m_state_in_vld", 32'(m_state_in_vld), 32'd0);
    chk("reset m_state_in", 32'(m_state_in), 32'd0);
    chk("reset total_hits", 32'(total_hits), 32'd0);
    chk("reset cnt_rd_data", 32'(cnt_rd_data), 32'd0);

    send_pkt(5, 0, 1, 2, 0, 0, 'h111, 0, 0);
    rd_cnt(5);

    send_pkt(3, 0, 1, 3, 0, 0, 'h2A5, 0, 0);
    send_pkt(3, 0, 1, 2, 0, 1, 'h2A6, 0, 0);
    rd_cnt(3);

    send_pkt(7, 0, 1, 1, 0, 0, 'h155, 0, 0);
    send_pkt(7, 0, 0, 3, 2, 1, 'h7FF, 1, 0);
    send_pkt(7, 0, 1, 1, 0, 0, 'h0AA, 0, 0);
    rd_cnt(7);

    send_pkt(12, 0, 1, 4, 4, 0, 'h044, 0, 0);
    rd_cnt(12);

    send_pkt(20, 0, 1, 2, 1, 0, 'h020, 0, 1);
    rd_cnt(21);
    rd_cnt(20);

    send_pkt(30, 0, 1, 0, 0, 0, 'h030, 0, 0);
    send_pkt(3, 1, 1, 2, 0, 0, 'h300, 0, 0);

    // Abort a packet with reset: valid bits and total clear, RAM contents stay stale.
    start_pkt(3, 0, 1, 'h3FF, 0);
    char_vld = 1'b1;
    @(posedge clk); #1;
    char_vld = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    m_total = 0;
    @(posedge clk); #1;
    chk("busy after mid-packet reset", 32'(busy), 32'd0);
    chk("total_hits after mid-packet reset", 32'(total_hits), 32'd0);
    rd_cnt(5);
    send_pkt(3, 0, 1, 1, 1, 0, 'h123, 0, 0);
    rd_cnt(3);

    for (int k = 0; k < 16; k++) send_pkt(9, 0, 1, 1, 1, 0, 'h009, 0, 0);
    rd_cnt(9);

    repeat (4) @(posedge clk);
    #1;
    chk("seed queue drained", 32'(seed_q.size()), 32'd0);
    chk("commit queue drained", 32'(cmt_q.size()), 32'd0);
    chk("read queue drained", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
